// File: rtl/seq_div_4bit.sv
// Sequential restoring divider: one shift-subtract iteration per clock,
// with a start/busy/done handshake toward the arithmetic-unit controller.
module seq_div_4bit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic [N-1:0]   d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;
  logic [N:0]     r_shift;
  logic           fits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The partial remainder always stays below the divisor, so it fits in N
  // bits; only the shifted value needs the extra bit for the comparison.
  always_comb begin
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    r_shift     = {r_q, q_q[N-1]};
    fits        = (r_shift >= {1'b0, d_q});
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d   = dividend;
          r_d   = '0;
          d_d   = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end
        end
      end
      CALC: begin
        q_d   = {q_q[N-2:0], fits};
        r_d   = fits ? (r_shift[N-1:0] - d_q) : r_shift[N-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          quotient_d  = q_d;
          remainder_d = r_d;
          dbz_d       = 1'b0;
          cnt_d       = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q == CALC);
    done        = (state_q == DONE);
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: doc/seq_div_4bit.md
Name: seq_div_4bit

Overview:
- Sequential restoring divider. It is the inverse-direction companion to the team's 4-bit array multiplier datapath.
- Accepts an unsigned dividend/divisor pair on a start pulse and produces quotient and remainder after N shift-subtract iterations.
- Sits beside the multiplier in the lab arithmetic unit and uses a start/busy/done handshake toward the controller.

Parameters:
- N, 4, operand width in bits for dividend, divisor, quotient and remainder. Legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  N  unsigned dividend; sampled on the accepted start edge.
- divisor  input  N  unsigned divisor; sampled on the accepted start edge.
- busy  output  1  high while CALC is active.
- done  output  1  one-cycle pulse; quotient and remainder are valid in this cycle.
- quotient  output  N  registered result.
- remainder  output  N  registered result.
- div_by_zero  output  1  registered flag; high when the last accepted operation had divisor == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy, done, div_by_zero = 0; quotient, remainder = 0; iteration counter = 0.
  - Reset is honoured at any time, including mid-CALC. The operation in progress is discarded and no done is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start = 1 at edge E latches the operands into working registers: Q = dividend, R = 0 (N+1 bits), D = divisor.
  - If divisor != 0: go to CALC with busy = 1 after edge E and counter = 0.
  - If divisor == 0: go directly to DONE and skip CALC. Load quotient = all ones and remainder = dividend, and set div_by_zero = 1. done is high in the cycle after E, so latency is 1 cycle.
- CALC, one iteration per edge:
  - R' = {R[N-1:0], Q[N-1]}; Q = Q << 1.
  - If R' >= {1'b0, D}: R = R' - D and Q[0] = 1. Otherwise R = R' and Q[0] = 0.
  - Comparison and subtraction are N+1 bits wide; no wrap-around is possible.
  - The counter increments each edge. On the N-th iteration edge (counter == N-1):
    - Load quotient = Q result and remainder = R[N-1:0] result.
    - Set div_by_zero = 0.
    - Go to DONE with busy = 0.
- DONE:
  - done = 1 for exactly one cycle, then IDLE on the next edge.
  - Latency for a nonzero divisor: done is high in the cycle after edge E+N, i.e. N+1 cycles after start is accepted.
- start handling:
  - start while in CALC or DONE is ignored; no queuing.
  - start held high continuously gives back-to-back operations: a new operand is accepted on the first edge seen in IDLE.
- Output stability:
  - quotient, remainder and div_by_zero change only on the edge entering DONE.
  - They hold their values through IDLE and the next CALC until the next result.
- Operand inputs may change freely after the start edge without affecting the result.
- busy and done are never high simultaneously.

Test Plan:
- N=4, reset, then start with dividend=13, divisor=3 -> busy high for 4 cycles; done pulses at cycle 5 after start; quotient=4, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0. Then dividend=5, divisor=7 -> quotient=0, remainder=5. Then dividend=0, divisor=9 -> quotient=0, remainder=0.
- dividend=9, divisor=0 -> no busy; done in the cycle after start; quotient=15, remainder=9, div_by_zero=1. A following 12/4 clears the flag and gives quotient=3, remainder=0.
- start=1 with 14/3, change operands to 1/1 mid-CALC, and re-pulse start during busy -> result stays 14/3: quotient=4, remainder=2, done exactly once.
- rst_n low for one cycle at iteration 2 of 11/2 -> all outputs 0 immediately and no done pulse. A subsequent 11/2 gives quotient=5, remainder=1.
- Exhaustive sweep of all 256 operand pairs with start held high -> every done matches the reference model (divisor 0 handled per rule). The result holds between done pulses.
